// File: rtl/des_f_pipe.sv
// DES round function f(R,K) = P(S(E(R) xor K)) behind a valid/ready pipeline.
// Optional macro DES_F_PIPE2_EN adds a registered output stage after P (latency 2).
module des_sbox #(
    parameter logic [255:0] TBL = '0
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    // Entry (row*16+col) sits at TBL[255-4*idx -: 4]; 255-4*idx == {~idx, 2'b11}.
    logic [5:0] idx;
    assign idx  = {din[5], din[0], din[4:1]};
    assign dout = TBL[{~idx, 2'b11} -: 4];
endmodule

module des_f_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r_in,
    input  logic [47:0] k_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_out,
    output logic        busy
);
    localparam int PT [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    // E: chunk c takes DES bits 4c..4c+5, wrapping 0->32 and 33->1.
    function automatic logic [47:0] e_exp(input logic [31:0] r);
        logic [47:0] e;
        int b;
        e = '0;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 6; j++) begin
                b = 4 * c + j;
                if (b == 0) b = 32;
                else if (b == 33) b = 1;
                e[47 - (6 * c + j)] = r[32 - b];
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] s);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 32; i++) f[31 - i] = s[32 - PT[i]];
        return f;
    endfunction

    logic [47:0] x;
    logic [31:0] s_d;
    logic [31:0] s_q;
    logic        v1;
    logic        rdy1;

    assign x = e_exp(r_in) ^ k_in;

    des_sbox #(.TBL(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
        S_Box_1 (.din(x[47:42]), .dout(s_d[31:28]));
    des_sbox #(.TBL(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
        S_Box_2 (.din(x[41:36]), .dout(s_d[27:24]));
    des_sbox #(.TBL(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
        S_Box_3 (.din(x[35:30]), .dout(s_d[23:20]));
    des_sbox #(.TBL(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
        S_Box_4 (.din(x[29:24]), .dout(s_d[19:16]));
    des_sbox #(.TBL(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
        S_Box_5 (.din(x[23:18]), .dout(s_d[15:12]));
    des_sbox #(.TBL(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
        S_Box_6 (.din(x[17:12]), .dout(s_d[11:8]));
    des_sbox #(.TBL(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
        S_Box_7 (.din(x[11:6]), .dout(s_d[7:4]));
    des_sbox #(.TBL(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
        S_Box_8 (.din(x[5:0]), .dout(s_d[3:0]));

`ifdef DES_F_PIPE2_EN
    logic [31:0] f_q;
    logic        v2;
    logic        rdy2;

    assign rdy2 = !v2 || out_ready;
    assign rdy1 = !v1 || rdy2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            f_q <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) f_q <= p_perm(s_q);
        end
    end

    assign out_valid = v2;
    assign f_out     = f_q;
    assign busy      = v1 | v2;
`else
    assign rdy1      = !v1 || out_ready;
    assign out_valid = v1;
    assign f_out     = p_perm(s_q);
    assign busy      = v1;
`endif

    // Data only loads on a real offer, so X on idle inputs never reaches s_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            s_q <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) s_q <= s_d;
        end
    end

    assign in_ready = rdy1;
endmodule

// File: tb/tb_des_f_pipe.sv
// Directed bench for des_f_pipe: known answers, streaming, backpressure, reset, S5 sweep.
module tb_des_f_pipe;
`ifdef DES_F_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r_in;
    logic [47:0] k_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f_out;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] vr [64];
    logic [47:0] vk [64];

    int ET [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int PT [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    des_f_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r_in(r_in), .k_in(k_in), .out_valid(out_valid), .out_ready(out_ready),
        .f_out(f_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmodel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] xx;
        logic [31:0] s, f;
        logic [5:0]  ch;
        int          row, col;
        for (int i = 1; i <= 48; i++) xx[48 - i] = r[32 - ET[i - 1]];
        xx = xx ^ k;
        for (int c = 1; c <= 8; c++) begin
            ch  = xx[(53 - 6 * c) -: 6];
            row = 2 * int'(ch[5]) + int'(ch[0]);
            col = int'(ch[4:1]);
            s[(35 - 4 * c) -: 4] = 4'(SB[c - 1][row * 16 + col]);
        end
        for (int i = 1; i <= 32; i++) f[32 - i] = s[32 - PT[i - 1]];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer with out_ready=1; inputs go X once the offer is taken.
    task automatic send_one(input string tag, input logic [31:0] r, input logic [47:0] k,
                            input logic [31:0] exp);
        int cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        r_in      = r;
        k_in      = k;
        tick();
        in_valid = 1'b0;
        r_in     = 'x;
        k_in     = 'x;
        cyc      = 1;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, LAT);
        chk(tag, f_out, exp);
        tick();
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Offers vr/vk[sent0..n-1] every cycle with out_ready=1 and collects n results.
    task automatic stream(input string tag, input int n, input int sent0);
        int sent = sent0, got = 0, lowrdy = 0, gap = 0, cyc = 0;
        bit started = 1'b0;
        out_ready = 1'b1;
        while (got < n && cyc < n + 20) begin
            in_valid = (sent < n);
            if (sent < n) begin
                r_in = vr[sent];
                k_in = vk[sent];
            end
            #1;
            if (in_valid && !in_ready) lowrdy++;
            if (out_valid) begin
                chk({tag, "_data"}, f_out, fmodel(vr[got], vk[got]));
                got++;
                started = 1'b1;
            end else if (started) begin
                gap++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, got, n);
        chk({tag, "_inrdy_low"}, lowrdy, 0);
        chk({tag, "_gaps"}, gap, 0);
    endtask

    initial begin
        int sent, lowseen, unstable;
        bit hset;
        logic [31:0] hf;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; r_in = '0; k_in = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_f_out", f_out, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Known answer and hand-computed directed vectors
        send_one("kat", 32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h234AA9BB);
        chk("kat_s_reg", dut.s_q, 32'h5C82B597);
        send_one("zero", 32'h0, 48'h0, 32'hD8D8DBBC);
        chk("zero_s_reg", dut.s_q, 32'hEFA72C4D);
        send_one("ones", 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 32'hD8D8DBBC);
        send_one("s5_max", 32'h0, 48'h000000FC0000, 32'hF8D8DBBC);
        send_one("r_only", 32'hFFFFFFFF, 48'h0, fmodel(32'hFFFFFFFF, 48'h0));

        // Back-to-back random stream
        for (int i = 0; i < 16; i++) begin
            vr[i] = $urandom;
            vk[i] = {16'($urandom), $urandom};
        end
        stream("b2b", 16, 0);

        // Backpressure: out_ready low for 5 cycles while offering 3 vectors
        for (int i = 0; i < 3; i++) begin
            vr[i] = $urandom;
            vk[i] = {16'($urandom), $urandom};
        end
        out_ready = 1'b0; sent = 0; lowseen = 0; unstable = 0; hset = 1'b0; hf = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (sent < 3);
            r_in = vr[sent < 3 ? sent : 2];
            k_in = vk[sent < 3 ? sent : 2];
            #1;
            if (!in_ready) lowseen = 1;
            if (out_valid) begin
                if (!hset) begin
                    hf   = f_out;
                    hset = 1'b1;
                end else if (f_out !== hf) begin
                    unstable++;
                end
            end else if (hset) begin
                unstable++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        chk("bp_inrdy_low", lowseen, 1);
        chk("bp_accepted", sent, LAT);
        chk("bp_unstable", unstable, 0);
        chk("bp_hold_val", hf, fmodel(vr[0], vk[0]));
        chk("bp_busy", {31'd0, busy}, 32'd1);
        stream("bp", 3, sent);

        // Reset with results in flight
        vr[0] = 32'h12345678; vk[0] = 48'hABCDEF012345;
        vr[1] = 32'h87654321; vk[1] = 48'h0F0F0F0F0F0F;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            r_in = vr[c];
            k_in = vk[c];
            tick();
        end
        in_valid = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_f_out", f_out, 32'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        send_one("post_rst", 32'hCAFEF00D, 48'h13579BDF2468, fmodel(32'hCAFEF00D, 48'h13579BDF2468));

        // S5 sweep: chunk 5 is x[23:18]; r=0 so x == k
        for (int v = 0; v < 64; v++) begin
            vr[v] = 32'h0;
            vk[v] = 48'(v) << 18;
        end
        stream("s5", 64, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/des_f_pipe.md
DES_F_PIPE -- requirements
Module: des_f_pipe

Interface
REQ-001 Parameters: none; the block has fixed widths as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 in_valid  input  1  upstream offers r_in/k_in this cycle.
REQ-005 in_ready  output  1  block accepts the offer this cycle.
REQ-006 r_in  input  32  Feistel right half R; DES bit 1 = r_in[31].
REQ-007 k_in  input  48  round subkey K; DES bit 1 = k_in[47].
REQ-008 out_valid  output  1  f_out holds a valid result.
REQ-009 out_ready  input  1  downstream accepts f_out this cycle.
REQ-010 f_out  output  32  f(R,K) = P(S(E(R) xor K)); DES bit 1 = f_out[31].
REQ-011 busy  output  1  high when any pipeline stage holds valid data.

Function
REQ-012 Input transfer occurs on a cycle with in_valid && in_ready; output transfer occurs on a cycle with out_valid && out_ready.
REQ-013 Stage A (combinational from inputs): x = E(r_in) xor k_in, using the FIPS 46-3 E table with bit 1 = MSB.
REQ-014 Chunk i (i = 1..8) = x[53-6i -: 6] drives existing S-box instance S_Box_i; its 6-bit in maps row = {in[5],in[0]}, col = in[4:1].
REQ-015 S-box outputs concatenate with S1 at bits [31:28] through S8 at bits [3:0] to form s[31:0].
REQ-016 f_out = P(s), using the FIPS 46-3 P table: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
REQ-017 Default build: one register stage holding s and a valid bit; P is applied combinationally from that register to f_out; latency is 1 cycle (accept at edge N gives out_valid high after edge N).
REQ-018 Each stage loads when it is empty or its contents are leaving the same cycle; stage ready = !stage_valid || downstream_ready; in_ready equals stage-1 ready.
REQ-019 Simultaneous accept and drain of a full stage: the new data replaces the old one, with no bubble and no loss; full throughput is 1 result per cycle.
REQ-020 Stall: while out_valid && !out_ready, f_out and out_valid hold stable, and in_ready is low once all stages are full.
REQ-021 out_valid never deasserts without a transfer; data is never duplicated or reordered.
REQ-022 The block ignores r_in/k_in when in_valid is low; X on those inputs does not propagate into valid state.
REQ-023 busy = OR of all stage valid bits.

Reset
REQ-024 rst_n low clears all stage valid bits immediately (asynchronously): out_valid=0, busy=0, in_ready=1.
REQ-025 Data registers reset to 0, so f_out = P(0) = 32'h0 during reset.
REQ-026 Reset asserted mid-operation discards in-flight results; the first accept after rst_n deasserts is the next result delivered.
REQ-027 rst_n deassertion is synchronised externally; the block takes no action on the release edge.

Configuration
REQ-028 Macro DES_F_PIPE2_EN: when defined, a second register stage is added after P, latency becomes 2 cycles, f_out is driven directly from a flop, and the REQ-018 rules apply per stage.
REQ-029 Without DES_F_PIPE2_EN, the single-stage behaviour of REQ-017 applies; the functional result is identical in both builds.

Verification
REQ-030 Known-answer: r_in=F0AAF0AA, k_in=1B02EFFC7072, out_ready=1 -> f_out=234AA9BB after 1 cycle (2 with DES_F_PIPE2_EN); the internal s register equals 5C82B597.
REQ-031 Zero vector: r_in=0, k_in=0 -> s=EFA72C4D, f_out=P(EFA72C4D) matching the golden model.
REQ-032 Back-to-back: 16 random vectors with in_valid=1 and out_ready=1 every cycle -> 16 results in order, in_ready always 1, no gaps.
REQ-033 Backpressure: out_ready=0 for 5 cycles while feeding 3 vectors -> in_ready drops after the pipeline fills, f_out holds stable, then all 3 results emerge in order when out_ready=1.
REQ-034 Reset mid-stream: assert rst_n low with 2 results in flight -> out_valid=0 and busy=0 immediately; after release, a new vector yields only its own result.
REQ-035 S5 sweep: vary chunk 5 over all 64 values with the other chunks 0 -> f_out matches the golden model for every value.
